// File: rtl/bsg_thermometer_count_pipe.sv
// bsg_thermometer_count_pipe
//
// Two-stage pipelined thermometer-code to binary counter. The incoming code is
// normalised so it always fills from bit 0, registered in S1, then the count
// (index of the lowest 0) and a malformed-code flag are computed and registered
// in S2. A saturating statistic counts erroneous outputs taken by the consumer.
//
// Ports:
//   clk_i      - clock
//   reset_n_i  - asynchronous active-low reset
//   v_i        - input valid
//   data_i     - thermometer code (width_p bits)
//   ready_o    - block accepts data_i this cycle (combinational on yumi_i)
//   v_o        - output valid (S2)
//   count_o    - binary count (cnt_width_lp bits), 0 when v_o is low
//   err_o      - current output came from a malformed code, 0 when v_o is low
//   yumi_i     - consumer takes the output this cycle (only while v_o)
//   clr_i      - synchronous clear of the error counter; wins over an increment
//   err_cnt_o  - saturating count of consumed erroneous outputs
module bsg_thermometer_count_pipe #(
    parameter int width_p         = 16,
    parameter int msb_first_p     = 0,
    parameter int err_cnt_width_p = 8,
    localparam int cnt_width_lp   = $clog2(width_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [cnt_width_lp-1:0]    count_o,
    output logic                       err_o,
    input  logic                       yumi_i,
    input  logic                       clr_i,
    output logic [err_cnt_width_p-1:0] err_cnt_o
);

    localparam logic [err_cnt_width_p-1:0] err_cnt_max_lp = '1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [err_cnt_width_p-1:0] sat_inc(
        input logic [err_cnt_width_p-1:0] val
    );
        if (val == err_cnt_max_lp) begin
            return val;
        end
        return val + err_cnt_width_p'(1);
    endfunction

    logic [width_p-1:0]         d_norm;
    logic                       s2_load;
    logic                       accept;

    logic                       s1_v_q,     s1_v_d;
    logic [width_p-1:0]         s1_data_q,  s1_data_d;

    logic [cnt_width_lp-1:0]    cnt_c;
    logic                       err_c;
    logic                       seen_zero;

    logic                       s2_v_q,     s2_v_d;
    logic [cnt_width_lp-1:0]    s2_count_q, s2_count_d;
    logic                       s2_err_q,   s2_err_d;

    logic [err_cnt_width_p-1:0] err_cnt_q,  err_cnt_d;

    // Bit-reverse MSB-first codes so the fill always starts at bit 0.
    always_comb begin
        d_norm = data_i;
        if (msb_first_p != 0) begin
            for (int i = 0; i < width_p; i++) begin
                d_norm[i] = data_i[width_p-1-i];
            end
        end
    end

    // S2 refills whenever it is empty or being consumed; S1 drains under the
    // same condition, so ready_o never depends on v_i.
    assign s2_load = !s2_v_q || yumi_i;
    assign ready_o = !s1_v_q || s2_load;
    assign accept  = v_i && ready_o;

    // ---- input -> S1 ----
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        if (accept) begin
            s1_v_d    = 1'b1;
            s1_data_d = d_norm;
        end else if (s2_load) begin
            s1_v_d    = 1'b0;
        end
    end

    // Count is the position of the first 0; any 1 seen after it marks the
    // code as malformed. All-ones leaves the count at width_p.
    always_comb begin
        cnt_c     = cnt_width_lp'(width_p);
        err_c     = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < width_p; i++) begin
            if (!s1_data_q[i]) begin
                if (!seen_zero) begin
                    cnt_c = cnt_width_lp'(i);
                end
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                err_c = 1'b1;
            end
        end
    end

    // ---- S1 -> S2 ----
    always_comb begin
        s2_v_d     = s2_v_q;
        s2_count_d = s2_count_q;
        s2_err_d   = s2_err_q;
        if (s2_load) begin
            // A bubble clears the result fields so idle outputs read 0.
            s2_v_d     = s1_v_q;
            s2_count_d = s1_v_q ? cnt_c : '0;
            s2_err_d   = s1_v_q && err_c;
        end
    end

    // ---- S2 -> error statistic ----
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            err_cnt_d = '0;
        end else if (s2_v_q && yumi_i && s2_err_q) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_q     <= 1'b0;
            s1_data_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_count_q <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_data_q  <= s1_data_d;
            s2_v_q     <= s2_v_d;
            s2_count_q <= s2_count_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign v_o       = s2_v_q;
    assign count_o   = s2_count_q;
    assign err_o     = s2_err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_bsg_thermometer_count_pipe.sv
// Testbench for bsg_thermometer_count_pipe.
// Main instance: width 16, LSB-first, 2-bit error counter (reaches saturation
// quickly). Second instance: width 5, MSB-first, always-consuming sink.
module tb_bsg_thermometer_count_pipe;

    localparam int W      = 16;
    localparam int EW     = 2;
    localparam int CW     = $clog2(W + 1);
    localparam int W2     = 5;
    localparam int CW2    = $clog2(W2 + 1);
    localparam int ERRMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          v_i, yumi_i, clr_i;
    logic [W-1:0]  data_i;
    logic          ready_o, v_o, err_o;
    logic [CW-1:0] count_o;
    logic [EW-1:0] err_cnt_o;

    logic           v2, ready2, v2_o, err2, yumi2;
    logic [W2-1:0]  data2;
    logic [CW2-1:0] count2;
    logic [7:0]     err_cnt2;

    bsg_thermometer_count_pipe #(
        .width_p(W), .msb_first_p(0), .err_cnt_width_p(EW)
    ) u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .count_o(count_o), .err_o(err_o),
        .yumi_i(yumi_i), .clr_i(clr_i), .err_cnt_o(err_cnt_o)
    );

    assign yumi2 = v2_o;

    bsg_thermometer_count_pipe #(
        .width_p(W2), .msb_first_p(1), .err_cnt_width_p(8)
    ) u_dut_msb (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v2), .data_i(data2),
        .ready_o(ready2), .v_o(v2_o), .count_o(count2), .err_o(err2),
        .yumi_i(yumi2), .clr_i(1'b0), .err_cnt_o(err_cnt2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: count trailing ones of the normalised code; the code is legal
    // exactly when it equals 2^count - 1.
    function automatic void ref_eval(input logic [31:0] code, input int w, input bit msb,
                                     output int cnt, output bit err);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < w; i++) d[i] = msb ? code[w-1-i] : code[i];
        cnt = 0;
        while (cnt < w && d[cnt]) cnt++;
        err = (d != ((32'd1 << cnt) - 32'd1));
    endfunction

    typedef struct {
        int cnt;
        bit err;
        int vis;   // first cycle in which this item may be on the output
    } item_t;

    item_t sb[$];
    int    popped[$];
    int    pop_cyc[$];
    int    cyc = 0;
    int    exp_errcnt = 0;
    bit    last_accept;
    int    last_acc_cyc;

    // One clock cycle on the main instance: apply inputs, check outputs
    // against the model, advance the model, move to the next negedge.
    task automatic step(input bit v, input logic [W-1:0] data, input bit yumi_req, input bit clr);
        bit    exp_v, exp_ready, yumi;
        item_t it;
        int    c;
        bit    e;
        exp_v  = (sb.size() > 0) && (sb[0].vis <= cyc);
        yumi   = yumi_req && exp_v;
        v_i    = v;
        data_i = data;
        yumi_i = yumi;
        clr_i  = clr;
        #1;
        chk("v_o", v_o, exp_v);
        if (exp_v) begin
            chk("count_o", count_o, sb[0].cnt);
            chk("err_o", err_o, sb[0].err);
        end else begin
            chk("count_o_idle", count_o, 0);
            chk("err_o_idle", err_o, 0);
        end
        exp_ready = !(sb.size() == 2 && !yumi);
        chk("ready_o", ready_o, exp_ready);
        chk("err_cnt_o", err_cnt_o, exp_errcnt);
        last_accept = v && exp_ready;
        if (yumi) begin
            popped.push_back(sb[0].cnt);
            pop_cyc.push_back(cyc);
            if (clr) exp_errcnt = 0;
            else if (sb[0].err && exp_errcnt < ERRMAX) exp_errcnt++;
            void'(sb.pop_front());
            if (sb.size() > 0 && sb[0].vis < cyc + 1) begin
                it = sb[0];
                it.vis = cyc + 1;
                sb[0] = it;
            end
        end else if (clr) begin
            exp_errcnt = 0;
        end
        if (last_accept) begin
            ref_eval(32'(data), W, 1'b0, c, e);
            it.cnt = c;
            it.err = e;
            it.vis = cyc + 2;
            sb.push_back(it);
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] gen_code();
        int          c;
        logic [31:0] t;
        c = $urandom_range(0, W);
        t = (32'd1 << c) - 32'd1;
        case ($urandom_range(0, 3))
            0, 1:    return W'(t);
            2:       return W'(t ^ (32'd1 << $urandom_range(0, W - 1)));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0]  sweep[5];
        int            sweep_exp[5];
        logic [W-1:0]  offq[$];
        logic [W2-1:0] list2[$];
        int            acc, c;
        bit            e, off_v;
        logic [W-1:0]  off_d;

        sweep     = '{16'h0000, 16'h0001, 16'h00FF, 16'h7FFF, 16'hFFFF};
        sweep_exp = '{0, 1, 8, 15, 16};

        reset_n = 1'b0;
        v_i = 0; data_i = '0; yumi_i = 0; clr_i = 0;
        v2 = 0; data2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_v_o", v_o, 0);
        chk("rst_count_o", count_o, 0);
        chk("rst_err_cnt_o", err_cnt_o, 0);
        chk("rst_v2_o", v2_o, 0);
        reset_n = 1'b1;

        // Sweep of legal codes, back-to-back with the consumer always ready.
        popped.delete(); pop_cyc.delete();
        for (int i = 0; i < 5; i++) step(1'b1, sweep[i], 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        chk("sweep_n", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++) begin
            chk("sweep_cnt", popped[i], sweep_exp[i]);
            chk("sweep_nobubble", pop_cyc[i] - pop_cyc[0], i);
        end

        // Malformed codes.
        popped.delete();
        step(1'b1, 16'h00F7, 1'b1, 1'b0);
        step(1'b1, 16'h8000, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        chk("malf_n", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("malf_cnt0", popped[0], 3);
            chk("malf_cnt1", popped[1], 0);
        end
        chk("malf_errcnt", err_cnt_o, 2);

        // Backpressure: three offers while the consumer stalls.
        popped.delete();
        offq = '{16'h00FF, 16'h000F, 16'h0003};
        acc = 0;
        repeat (5) begin
            step(offq.size() > 0, (offq.size() > 0) ? offq[0] : '0, 1'b0, 1'b0);
            if (last_accept) begin void'(offq.pop_front()); acc++; end
        end
        chk("bp_accepted", acc, 2);
        repeat (6) begin
            step(offq.size() > 0, (offq.size() > 0) ? offq[0] : '0, 1'b1, 1'b0);
            if (last_accept) begin void'(offq.pop_front()); acc++; end
        end
        chk("bp_total", acc, 3);
        chk("bp_n", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("bp_order0", popped[0], 8);
            chk("bp_order1", popped[1], 4);
            chk("bp_order2", popped[2], 2);
        end

        // Asynchronous reset with two items in flight and a nonzero statistic.
        step(1'b1, 16'h00FF, 1'b0, 1'b0);
        step(1'b1, 16'h0FFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_v_o", v_o, 0);
        chk("arst_count_o", count_o, 0);
        chk("arst_err_o", err_o, 0);
        chk("arst_err_cnt_o", err_cnt_o, 0);
        sb.delete();
        exp_errcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        popped.delete(); pop_cyc.delete();
        step(1'b1, 16'h0007, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_n", popped.size(), 1);
        if (popped.size() == 1) begin
            chk("post_rst_cnt", popped[0], 3);
            chk("post_rst_latency", pop_cyc[0] - last_acc_cyc, 2);
        end

        // Saturation, then clear colliding with an erroneous consume.
        repeat (5) step(1'b1, 16'h8000, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        chk("sat_errcnt", err_cnt_o, ERRMAX);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        chk("sat_hold", err_cnt_o, ERRMAX);
        step(1'b1, 16'h8000, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("clr_wins", err_cnt_o, 0);

        // Randomised traffic with a source that holds unaccepted offers.
        off_v = 1'b0;
        off_d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!off_v && $urandom_range(0, 3) != 0) begin
                off_v = 1'b1;
                off_d = gen_code();
            end
            step(off_v, off_d, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            if (last_accept) off_v = 1'b0;
        end
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // MSB-first instance, consumer always takes output: fixed latency 2.
        list2.push_back(5'b11100);
        list2.push_back(5'b01100);
        repeat (30) list2.push_back(W2'($urandom_range(0, 31)));
        for (int k = 0; k < list2.size() + 2; k++) begin
            v2    = (k < list2.size());
            data2 = (k < list2.size()) ? list2[k] : '0;
            #1;
            chk("msb_ready", ready2, 1);
            if (k >= 2) begin
                ref_eval(32'(list2[k-2]), W2, 1'b1, c, e);
                chk("msb_v_o", v2_o, 1);
                chk("msb_count", count2, c);
                chk("msb_err", err2, e);
                if (k == 2) begin
                    chk("msb_11100_cnt", count2, 3);
                    chk("msb_11100_err", err2, 0);
                end
                if (k == 3) begin
                    chk("msb_01100_cnt", count2, 0);
                    chk("msb_01100_err", err2, 1);
                end
            end else begin
                chk("msb_v_o_idle", v2_o, 0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        v2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
